decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 139 +++++++++++++
 tb/tb_decode_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
// Collects a 1..3 byte instruction from fetch (opcode, optional LSB, optional
// MSB), decodes the opcode into type/mode/size and presents the assembled
// instruction to execute until execute stops halting.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   f_to_d_byte   instruction byte from fetch
//   f_to_d_pc     address of f_to_d_byte
//   f_to_d_valid  fetch byte/pc valid
//   f_to_d_ready  decode accepts a byte this cycle
//   halt_d_to_e   execute busy, hold the presented instruction
//   reg_write     execute register-write strobe
//   reg_addr      execute register-write target (3 = PC, causes a flush)
//   d_to_e_reg    [7:0] LSB, [15:8] MSB, [31:16] PC, [35:32] mode,
//                 [37:36] size, [38] valid, [44:39] type
// ----------------------------------------------------------------------------
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  f_to_d_byte,
  input  logic [15:0] f_to_d_pc,
  input  logic        f_to_d_valid,
  output logic        f_to_d_ready,
  input  logic        halt_d_to_e,
  input  logic        reg_write,
  input  logic [2:0]  reg_addr,
  output logic [44:0] d_to_e_reg
);

  typedef enum logic [1:0] {
    S_OPC = 2'd0,
    S_OP1 = 2'd1,
    S_OP2 = 2'd2,
    S_OUT = 2'd3
  } state_t;

  state_t      state_r;
  logic        flush_s;
  logic        xfer_s;
  logic [11:0] dec_s;

  // Opcode lookup, packed as {type[5:0], mode[3:0], size[1:0]}.
  // Unknown opcodes decode as a 1-byte instruction so size is never 0.
  function automatic logic [11:0] decode_opcode(input logic [7:0] op);
    logic [11:0] d;
    case (op)
      8'h01:   d = {6'd35, 4'd9,  2'd2};
      8'h05:   d = {6'd35, 4'd4,  2'd2};
      8'h09:   d = {6'd35, 4'd2,  2'd2};
      8'h0D:   d = {6'd35, 4'd3,  2'd3};
      8'h11:   d = {6'd35, 4'd10, 2'd2};
      8'h0A:   d = {6'd3,  4'd1,  2'd1};
      8'h10:   d = {6'd10, 4'd8,  2'd2};
      8'h90:   d = {6'd4,  4'd8,  2'd2};
      8'hB0:   d = {6'd5,  4'd8,  2'd2};
      8'hF0:   d = {6'd6,  4'd8,  2'd2};
      8'h29:   d = {6'd2,  4'd2,  2'd2};
      8'h69:   d = {6'd1,  4'd2,  2'd2};
      8'h6D:   d = {6'd1,  4'd3,  2'd3};
      8'h7D:   d = {6'd1,  4'd6,  2'd3};
      8'h79:   d = {6'd1,  4'd13, 2'd3};
      8'h75:   d = {6'd1,  4'd5,  2'd2};
      default: d = {6'd0,  4'd7,  2'd1};
    endcase
    return d;
  endfunction

  // Handshake: ready is dropped combinationally during a PC write so a byte
  // offered on the flushing edge is never consumed.
  always_comb begin
    flush_s      = reg_write && (reg_addr == 3'd3);
    f_to_d_ready = (state_r != S_OUT) && !flush_s;
    xfer_s       = f_to_d_valid && f_to_d_ready;
    dec_s        = decode_opcode(f_to_d_byte);
  end

  // Instruction assembly FSM; d_to_e_reg doubles as the partial-field store.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_OPC;
      d_to_e_reg <= 45'd0;
    end else if (flush_s) begin
      state_r        <= S_OPC;
      d_to_e_reg[38] <= 1'b0;
    end else begin
      case (state_r)
        S_OPC: begin
          if (xfer_s) begin
            d_to_e_reg[44:39] <= dec_s[11:6];
            d_to_e_reg[35:32] <= dec_s[5:2];
            d_to_e_reg[37:36] <= dec_s[1:0];
            d_to_e_reg[31:16] <= f_to_d_pc;
            d_to_e_reg[15:0]  <= 16'd0;
            if (dec_s[1:0] == 2'd1) begin
              state_r        <= S_OUT;
              d_to_e_reg[38] <= 1'b1;
            end else begin
              state_r <= S_OP1;
            end
          end
        end
        S_OP1: begin
          if (xfer_s) begin
            d_to_e_reg[7:0] <= f_to_d_byte;
            if (d_to_e_reg[37:36] == 2'd2) begin
              state_r        <= S_OUT;
              d_to_e_reg[38] <= 1'b1;
            end else begin
              state_r <= S_OP2;
            end
          end
        end
        S_OP2: begin
          if (xfer_s) begin
            d_to_e_reg[15:8] <= f_to_d_byte;
            state_r          <= S_OUT;
            d_to_e_reg[38]   <= 1'b1;
          end
        end
        S_OUT: begin
          // Retiring always passes through OPC, so valid drops for at least
          // one cycle between instructions.
          if (!halt_d_to_e) begin
            state_r        <= S_OPC;
            d_to_e_reg[38] <= 1'b0;
          end
        end
        default: begin
          state_r        <= S_OPC;
          d_to_e_reg[38] <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
// Directed scenarios followed by randomized traffic, all checked against a
// byte-queue reference model of the decode stage.
// ----------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  f_to_d_byte;
  logic [15:0] f_to_d_pc;
  logic        f_to_d_valid;
  logic        f_to_d_ready;
  logic        halt_d_to_e;
  logic        reg_write;
  logic [2:0]  reg_addr;
  logic [44:0] d_to_e_reg;

  int checks_cnt = 0;
  int errors_cnt = 0;

  decode_stage dut (
    .clk          (clk),
    .rst          (rst),
    .f_to_d_byte  (f_to_d_byte),
    .f_to_d_pc    (f_to_d_pc),
    .f_to_d_valid (f_to_d_valid),
    .f_to_d_ready (f_to_d_ready),
    .halt_d_to_e  (halt_d_to_e),
    .reg_write    (reg_write),
    .reg_addr     (reg_addr),
    .d_to_e_reg   (d_to_e_reg)
  );

  always #5 clk = ~clk;

  // Opcode table: opcode, type, mode, size
  logic [7:0] tbl_op   [0:15] = '{8'h01, 8'h05, 8'h09, 8'h0D, 8'h11, 8'h0A, 8'h10, 8'h90,
                                  8'hB0, 8'hF0, 8'h29, 8'h69, 8'h6D, 8'h7D, 8'h79, 8'h75};
  int         tbl_type [0:15] = '{35, 35, 35, 35, 35, 3, 10, 4, 5, 6, 2, 1, 1, 1, 1, 1};
  int         tbl_mode [0:15] = '{9, 4, 2, 3, 10, 1, 8, 8, 8, 8, 2, 2, 3, 6, 13, 5};
  int         tbl_size [0:15] = '{2, 2, 2, 3, 2, 1, 2, 2, 2, 2, 2, 2, 3, 3, 3, 2};

  // Reference model: bytes of the current instruction and whether it is shown
  logic [7:0]  m_bytes[$];
  logic [15:0] m_pc;
  bit          m_pres;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [7:0] op, output int t, output int m, output int s);
    t = 0; m = 7; s = 1;
    for (int i = 0; i < 16; i++) begin
      if (tbl_op[i] == op) begin
        t = tbl_type[i]; m = tbl_mode[i]; s = tbl_size[i];
      end
    end
  endfunction

  function automatic logic [44:0] model_word();
    int t, m, s;
    logic [7:0] lsb, msb;
    lookup(m_bytes[0], t, m, s);
    lsb = (m_bytes.size() > 1) ? m_bytes[1] : 8'h00;
    msb = (m_bytes.size() > 2) ? m_bytes[2] : 8'h00;
    return {t[5:0], 1'b1, s[1:0], m[3:0], m_pc, msb, lsb};
  endfunction

  // One clock cycle: drive, check ready, advance model, check outputs.
  task automatic cyc(input logic v, input logic [7:0] b, input logic [15:0] p,
                     input logic h, input logic rw, input logic [2:0] ra, input logic r);
    bit flush, exp_rdy, xfer;
    int t, m, s;
    f_to_d_valid = v; f_to_d_byte = b; f_to_d_pc = p;
    halt_d_to_e = h; reg_write = rw; reg_addr = ra; rst = r;
    flush   = rw && (ra == 3'd3);
    exp_rdy = !m_pres && !flush;
    xfer    = v && exp_rdy;
    #1;
    check_eq("ready", {63'd0, f_to_d_ready}, {63'd0, exp_rdy});
    @(posedge clk);
    if (r) begin
      m_bytes.delete(); m_pres = 1'b0;
    end else if (flush) begin
      m_bytes.delete(); m_pres = 1'b0;
    end else if (m_pres) begin
      if (!h) begin
        m_bytes.delete(); m_pres = 1'b0;
      end
    end else if (xfer) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 1) m_pc = p;
      lookup(m_bytes[0], t, m, s);
      if (m_bytes.size() == s) m_pres = 1'b1;
    end
    #1;
    check_eq("valid", {63'd0, d_to_e_reg[38]}, {63'd0, m_pres});
    if (r) check_eq("reset_word", {19'd0, d_to_e_reg}, 64'd0);
    if (m_pres) check_eq("word", {19'd0, d_to_e_reg}, {19'd0, model_word()});
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 16'h0000, h, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    m_pres = 1'b0;
    m_pc   = 16'h0000;
    @(negedge clk);
    cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1);
    cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1);

    // 01,20 at 8000: type 35 mode 9 size 2, valid for one cycle
    cyc(1'b1, 8'h01, 16'h8000, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 8'h20, 16'h8001, 1'b0, 1'b0, 3'd0, 1'b0);
    check_eq("req029_word", {19'd0, d_to_e_reg},
             {19'd0, 6'd35, 1'b1, 2'd2, 4'd9, 16'h8000, 8'h00, 8'h20});
    idle(2, 1'b0);

    // 6D,34,(gap 2),12
    cyc(1'b1, 8'h6D, 16'h0100, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 8'h34, 16'h0101, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 8'h12, 16'h0102, 1'b1, 1'b0, 3'd0, 1'b0);
    check_eq("req030_word", {19'd0, d_to_e_reg},
             {19'd0, 6'd1, 1'b1, 2'd3, 4'd3, 16'h0100, 8'h12, 8'h34});
    idle(2, 1'b0);

    // 10,05 held by halt for 4 cycles, fetch keeps offering a byte
    cyc(1'b1, 8'h10, 16'h0200, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 8'h05, 16'h0201, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h0A, 16'h0202, 1'b1, 1'b0, 3'd0, 1'b0);
    check_eq("req031_word", {19'd0, d_to_e_reg},
             {19'd0, 6'd10, 1'b1, 2'd2, 4'd8, 16'h0200, 8'h00, 8'h05});
    idle(2, 1'b0);

    // back-to-back 0A,0A
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h0A, 16'h0300, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(1, 1'b0);

    // 0D,34 then flush while 12 offered, then A9 decodes as opcode
    cyc(1'b1, 8'h0D, 16'h0400, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 8'h34, 16'h0401, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 8'h12, 16'h0402, 1'b0, 1'b1, 3'd3, 1'b0);
    cyc(1'b1, 8'hA9, 16'h0403, 1'b1, 1'b0, 3'd0, 1'b0);
    check_eq("req033_word", {19'd0, d_to_e_reg},
             {19'd0, 6'd0, 1'b1, 2'd1, 4'd7, 16'h0403, 8'h00, 8'h00});
    idle(1, 1'b0);

    // FF then reset while presented
    cyc(1'b1, 8'hFF, 16'h0500, 1'b1, 1'b0, 3'd0, 1'b0);
    check_eq("req034_word", {19'd0, d_to_e_reg},
             {19'd0, 6'd0, 1'b1, 2'd1, 4'd7, 16'h0500, 8'h00, 8'h00});
    cyc(1'b1, 8'h01, 16'h0501, 1'b1, 1'b0, 3'd0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [7:0]  b;
      logic [2:0]  ra;
      logic        rw, r;
      if ($urandom_range(1, 0) == 1) b = tbl_op[$urandom_range(15, 0)];
      else                           b = 8'($urandom);
      rw = ($urandom_range(19, 0) == 0);
      ra = ($urandom_range(1, 0) == 1) ? 3'd3 : 3'($urandom);
      r  = ($urandom_range(59, 0) == 0);
      cyc(($urandom_range(3, 0) != 0), b, 16'($urandom),
          ($urandom_range(2, 0) == 0), rw, ra, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
